// File: rtl/rex_vga_renderer.sv
// rtl/rex_vga_renderer.sv - 640x480@60 VGA renderer for the rex game (optional macro REX_RENDER_BLINK_EN)
// Game inputs are latched once per frame in vertical blanking; all outputs come from one register stage.
module rex_vga_renderer #(
    parameter int DINO_X   = 16,
    parameter int DINO_W   = 16,
    parameter int DINO_H   = 20,
    parameter int OBS_W    = 16,
    parameter int OBS_H    = 26,
    parameter int GROUND_Y = 400,
    parameter int SCALE_SH = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] rex_y,
    input  logic [15:0] obstacle_x,
    input  logic [1:0]  state,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_tick
);
    localparam logic [11:0] DINO_X0  = 12'(DINO_X << SCALE_SH);
    localparam logic [11:0] DINO_X1  = 12'((DINO_X + DINO_W) << SCALE_SH);
    localparam logic [11:0] DINO_HS  = 12'(DINO_H << SCALE_SH);
    localparam logic [11:0] GROUND   = 12'(GROUND_Y);
    localparam logic [11:0] OBS_TOP  = 12'(GROUND_Y - (OBS_H << SCALE_SH));
    localparam logic [17:0] OBS_WS   = 18'(OBS_W);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [5:0]  s_y_q, s_y_d;
    logic [15:0] s_x_q, s_x_d;
    logic [1:0]  s_st_q, s_st_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, frame_tick_q, frame_tick_d;
    logic [11:0] rgb_q, rgb_d;
    logic        snap;
    logic [11:0] px, py, bot, dino_top, bg;
    logic [17:0] obs_lo, obs_hi;
    logic        in_dino, in_obs, on_ground;
`ifdef REX_RENDER_BLINK_EN
    logic [4:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_ph_q, blink_ph_d;
`endif

    always_comb begin
        h_d = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
        v_d = v_q;
        if (h_q == 10'd799) v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;

        // Snapshot sits in vertical blanking so no visible pixel sees a half-updated frame.
        snap   = (h_q == 10'd0) && (v_q == 10'd480);
        s_y_d  = s_y_q;
        s_x_d  = s_x_q;
        s_st_d = s_st_q;
        if (snap) begin
            s_y_d  = (rex_y > 16'd63) ? 6'd63 : rex_y[5:0];
            s_x_d  = obstacle_x;
            s_st_d = state;
        end

        px       = {2'b00, h_q};
        py       = {2'b00, v_q};
        bot      = GROUND - (12'(s_y_q) << SCALE_SH);
        dino_top = bot - DINO_HS;
        in_dino  = (px >= DINO_X0) && (px < DINO_X1) && (py >= dino_top) && (py < bot);

        // Wide obstacle math so far-right positions cannot wrap back on screen.
        obs_lo = 18'(s_x_q) << SCALE_SH;
        obs_hi = (18'(s_x_q) + OBS_WS) << SCALE_SH;
        in_obs = (obs_lo < 18'd640) && (18'(h_q) >= obs_lo) && (18'(h_q) < obs_hi)
                 && (py >= OBS_TOP) && (py < GROUND);
        on_ground = (py == GROUND);

`ifdef REX_RENDER_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (s_st_q != 2'd3) begin
            blink_cnt_d = 5'd0;
            blink_ph_d  = 1'b0;
        end else if (frame_tick_q) begin
            blink_cnt_d = blink_cnt_q + 5'd1;
            if (blink_cnt_q == 5'd31) blink_ph_d = ~blink_ph_q;
        end
        bg = blink_ph_q ? 12'hFCC : 12'hFFF;
`else
        bg = 12'hFFF;
`endif

        hsync_d      = !((h_q >= 10'd656) && (h_q <= 10'd751));
        vsync_d      = !((v_q >= 10'd490) && (v_q <= 10'd491));
        de_d         = (h_q < 10'd640) && (v_q < 10'd480);
        frame_tick_d = snap;

        if (!de_d)          rgb_d = 12'h000;
        else if (in_dino)   rgb_d = (s_st_q == 2'd3) ? 12'hF00 : 12'h333;
        else if (in_obs)    rgb_d = 12'h0A0;
        else if (on_ground) rgb_d = 12'h888;
        else                rgb_d = bg;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_q          <= 10'd0;
            v_q          <= 10'd0;
            s_y_q        <= 6'd0;
            s_x_q        <= 16'd0;
            s_st_q       <= 2'd0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
            rgb_q        <= 12'h000;
            frame_tick_q <= 1'b0;
`ifdef REX_RENDER_BLINK_EN
            blink_cnt_q  <= 5'd0;
            blink_ph_q   <= 1'b0;
`endif
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            s_y_q        <= s_y_d;
            s_x_q        <= s_x_d;
            s_st_q       <= s_st_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
`ifdef REX_RENDER_BLINK_EN
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
`endif
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign de         = de_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;
endmodule
